// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the Common Data Bus arbiter slice:
//   - default issuer count and CDB field widths
//   - fixed issuer index assignments (ALU, LSU, branch unit)
//   - idx_width(): index width of a table with n entries, never below 1 bit
// No ports (package).
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  // Index width for n entries; a single-entry table still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CDB_NUM_REQ        = 3;
  localparam int CDB_DATA_WIDTH     = 32;
  localparam int CDB_ROB_ENTRY      = 4;
  localparam int CDB_ROB_ENTRY_LOG2 = idx_width(CDB_ROB_ENTRY);

  localparam int ISSUER_ALU = 0;
  localparam int ISSUER_LSU = 1;
  localparam int ISSUER_BRU = 2;

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the issuer request side and the CDB broadcast side.
//   req_request [NUM_REQ]                 per-issuer request
//   req_data    [NUM_REQ*DATA_WIDTH]      issuer i result at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_id      [NUM_REQ*ROB_ENTRY_LOG2]  issuer i ROB tag at [i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]
//   req_grant   [NUM_REQ]                 one-hot/zero grant (combinational)
//   flush                                 pipeline flush
//   cdb_valid / cdb_data / cdb_id         registered broadcast
// Modports:
//   master - issuers/consumers side (drives requests and flush)
//   slave  - arbiter side (drives grant and broadcast)
// -----------------------------------------------------------------------------
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = CDB_NUM_REQ,
  parameter int DATA_WIDTH     = CDB_DATA_WIDTH,
  parameter int ROB_ENTRY_LOG2 = CDB_ROB_ENTRY_LOG2
) ();

  logic [NUM_REQ-1:0]                req_request;
  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data;
  logic [NUM_REQ*ROB_ENTRY_LOG2-1:0] req_id;
  logic [NUM_REQ-1:0]                req_grant;
  logic                              flush;
  logic                              cdb_valid;
  logic [DATA_WIDTH-1:0]             cdb_data;
  logic [ROB_ENTRY_LOG2-1:0]         cdb_id;

  modport master (
    output req_request, req_data, req_id, flush,
    input  req_grant, cdb_valid, cdb_data, cdb_id
  );

  modport slave (
    input  req_request, req_data, req_id, flush,
    output req_grant, cdb_valid, cdb_data, cdb_id
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick among N requesters. The scan starts
// at index ptr and wraps modulo N; the first requesting index wins.
//   req_i     [N]   request vector
//   ptr_i     [PW]  highest-priority index (0..N-1)
//   en_i            when low no grant is produced
//   gnt_o     [N]   one-hot grant, all-zero when nothing wins
//   idx_o     [PW]  encoded winner index (0 when nothing wins)
//   any_gnt_o       a grant was produced
// -----------------------------------------------------------------------------
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = CDB_NUM_REQ,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_gnt_o
);

  // (p + k) mod N, computed one bit wider so the sum cannot overflow before
  // the single conditional subtract (p < N and k < N, so one subtract suffices).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(k);
    if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
    return s[PW-1:0];
  endfunction

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    idx_o     = '0;
    any_gnt_o = 1'b0;
    cand      = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        cand = wrap_add(ptr_i, k);
        if (!any_gnt_o && req_i[cand]) begin
          any_gnt_o   = 1'b1;
          gnt_o[cand] = 1'b1;
          idx_o       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the Common Data Bus among NUM_REQ issuers with round-robin priority.
// The grant is combinational in the request cycle; the winner's result and
// ROB tag are registered and broadcast one cycle later.
//   CLK   rising-edge clock
//   RSTN  asynchronous active-low reset
//   cdb   cdb_arbiter_if.slave: requests/data/ids/flush in, grant and
//         cdb_valid/cdb_data/cdb_id out (interface parameters must match)
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = CDB_NUM_REQ,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int ROB_ENTRY  = CDB_ROB_ENTRY
) (
  input  logic         CLK,
  input  logic         RSTN,
  cdb_arbiter_if.slave cdb
);

  localparam int ROB_ENTRY_LOG2 = idx_width(ROB_ENTRY);
  localparam int PTR_W          = idx_width(NUM_REQ);

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      cdb_valid_q, cdb_valid_d;
  logic [DATA_WIDTH-1:0]     cdb_data_q, cdb_data_d;
  logic [ROB_ENTRY_LOG2-1:0] cdb_id_q, cdb_id_d;

  logic                      arb_en;
  logic [NUM_REQ-1:0]        gnt;
  logic [PTR_W-1:0]          win_idx;
  logic                      any_gnt;
  logic [DATA_WIDTH-1:0]     win_data;
  logic [ROB_ENTRY_LOG2-1:0] win_id;

  // Grant is suppressed during flush and while reset is held, so no issuer
  // sees a handshake it could act on in either case.
  assign arb_en = RSTN & ~cdb.flush;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr (
    .req_i     (cdb.req_request),
    .ptr_i     (rr_ptr_q),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .idx_o     (win_idx),
    .any_gnt_o (any_gnt)
  );

  assign cdb.req_grant = gnt;

  // One-hot AND-OR select of the winner's result and tag.
  always_comb begin
    win_data = '0;
    win_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_data = cdb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        win_id   = cdb.req_id[i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
      end
    end
  end

  // Pointer moves just past the winner; data/id hold when nothing is granted
  // so the bus keeps its last broadcast value while idle.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = any_gnt;
    cdb_data_d  = cdb_data_q;
    cdb_id_d    = cdb_id_q;
    if (any_gnt) begin
      rr_ptr_d   = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);
      cdb_data_d = win_data;
      cdb_id_d   = win_id;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_id_q    <= cdb_id_d;
    end
  end

  assign cdb.cdb_valid = cdb_valid_q;
  assign cdb.cdb_data  = cdb_data_q;
  assign cdb.cdb_id    = cdb_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter (NUM_REQ=3, DATA_WIDTH=32, ROB_ENTRY=4).
// The driver issues one request pattern per cycle on the falling edge, checks
// the combinational grant, and queues the broadcast it expects next cycle.
// An independent monitor pops that queue whenever cdb_valid is seen.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } bcast_t;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  bcast_t        exp_q[$];
  logic [DW-1:0] d   [NR];
  logic [IW-1:0] idv [NR];

  cdb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ROB_ENTRY_LOG2(IW)) bus ();

  cdb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ROB_ENTRY(4)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .cdb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic pack();
    bus.req_data = {d[2], d[1], d[0]};
    bus.req_id   = {idv[2], idv[1], idv[0]};
  endtask

  // One cycle of stimulus: drive on the falling edge, check grant before the
  // next rising edge, queue the expected broadcast for the granted issuer.
  task automatic cyc(input logic [NR-1:0] req, input logic fl,
                     input logic [NR-1:0] exp_g, input string nm);
    bcast_t b;
    @(negedge clk);
    pack();
    bus.req_request = req;
    bus.flush       = fl;
    #2;
    chk(nm, 32'(bus.req_grant), 32'(exp_g));
    for (int i = 0; i < NR; i++) begin
      if (exp_g[i]) begin
        b.data = d[i];
        b.id   = idv[i];
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    bus.req_request = '0;
    bus.flush       = 1'b0;
    rstn            = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: every broadcast must match the oldest queued expectation.
  initial begin
    bcast_t b;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && bus.cdb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        end else begin
          b = exp_q.pop_front();
          chk("cdb_data", bus.cdb_data, b.data);
          chk("cdb_id", 32'(bus.cdb_id), 32'(b.id));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < NR; i++) begin
      d[i]   = 32'h1111_0000 + 32'(i);
      idv[i] = IW'(i);
    end
    pack();
    bus.req_request = 3'b111;
    bus.flush       = 1'b0;
    rstn            = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_cdb_data", bus.cdb_data, 32'd0);
    chk("rst_cdb_id", 32'(bus.cdb_id), 32'd0);
    chk("rst_grant_forced0", 32'(bus.req_grant), 32'd0);
    bus.req_request = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Single request from issuer 0
    d[0] = 32'h0000_1234; idv[0] = 2'd2;
    cyc(3'b001, 1'b0, 3'b001, "t1_grant");
    cyc(3'b000, 1'b0, 3'b000, "t1_idle");
    // pointer now 1: issuer 0 loses priority to issuer 1
    cyc(3'b011, 1'b0, 3'b010, "t1_ptr_is_1");
    cyc(3'b000, 1'b0, 3'b000, "t1_idle2");

    // Two requesters alternate from reset
    reset_dut();
    d[0] = 32'h0000_00A0; idv[0] = 2'd1;
    d[2] = 32'h0000_00C2; idv[2] = 2'd3;
    cyc(3'b101, 1'b0, 3'b001, "t2_g0");
    cyc(3'b101, 1'b0, 3'b100, "t2_g1");
    cyc(3'b101, 1'b0, 3'b001, "t2_g2");
    cyc(3'b100, 1'b0, 3'b100, "t2_g3");
    cyc(3'b000, 1'b0, 3'b000, "t2_idle");

    // Full contention, pointer wraps 2 -> 0
    d[0] = 32'h0000_0011; idv[0] = 2'd0;
    d[1] = 32'h0000_0022; idv[1] = 2'd1;
    d[2] = 32'h0000_0033; idv[2] = 2'd2;
    cyc(3'b111, 1'b0, 3'b001, "t3_c0");
    cyc(3'b111, 1'b0, 3'b010, "t3_c1");
    cyc(3'b111, 1'b0, 3'b100, "t3_c2");
    cyc(3'b111, 1'b0, 3'b001, "t3_c3");
    cyc(3'b111, 1'b0, 3'b010, "t3_c4");
    cyc(3'b111, 1'b0, 3'b100, "t3_c5");
    cyc(3'b000, 1'b0, 3'b000, "t3_idle");

    // Flush masks the grant and holds the pointer (0)
    cyc(3'b011, 1'b1, 3'b000, "t4_flush_grant");
    cyc(3'b011, 1'b0, 3'b001, "t4_resume_ptr0");
    chk("t4_valid_after_flush", 32'(bus.cdb_valid), 32'd0);
    cyc(3'b000, 1'b0, 3'b000, "t4_idle");

    // Idle after a broadcast: data/id hold, pointer holds (1 -> 2 after grant)
    d[1] = 32'hDEAD_BEEF; idv[1] = 2'd1;
    cyc(3'b010, 1'b0, 3'b010, "t5_grant");
    for (int i = 0; i < 3; i++) begin
      cyc(3'b000, 1'b0, 3'b000, "t5_idle_grant");
      if (i > 0) chk("t5_idle_valid", 32'(bus.cdb_valid), 32'd0);
      chk("t5_idle_data", bus.cdb_data, 32'hDEAD_BEEF);
      chk("t5_idle_id", 32'(bus.cdb_id), 32'd1);
    end
    cyc(3'b111, 1'b0, 3'b100, "t5_ptr_held_2");

    // Asynchronous reset while a broadcast is on the bus with pointer 2
    d[1] = 32'h5555_0001; idv[1] = 2'd3;
    cyc(3'b010, 1'b0, 3'b010, "t6_pre");
    @(posedge clk);
    #3;
    bus.req_request = 3'b111;
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.cdb_valid), 32'd0);
    chk("t6_rst_data", bus.cdb_data, 32'd0);
    chk("t6_rst_id", 32'(bus.cdb_id), 32'd0);
    chk("t6_rst_grant", 32'(bus.req_grant), 32'd0);
    @(negedge clk);
    bus.req_request = '0;
    @(negedge clk);
    rstn = 1'b1;
    d[2] = 32'h0000_0777; idv[2] = 2'd2;
    cyc(3'b100, 1'b0, 3'b100, "t6_after_grant");
    cyc(3'b011, 1'b0, 3'b001, "t6_ptr_wrapped_0");
    cyc(3'b000, 1'b0, 3'b000, "t6_idle");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single Common Data Bus (CDB) among NUM_REQ functional-unit issuers (ALU, LSU, branch unit, ...). It grants at most one requester per cycle using round-robin priority. The winner's result and ROB tag are registered and broadcast to the ROB and the reservation stations one cycle after the grant. It sits between the functional-unit result stages and the CDB consumers, and honours a pipeline flush.

Parameters:
NUM_REQ, 3, number of issuers sharing the CDB (2..8)
DATA_WIDTH, 32, result width
ROB_ENTRY, 4, ROB depth; ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY) is a derived localparam (min 1)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RSTN  input  1  reset, asynchronous, active-low
req_request  input  NUM_REQ  per-issuer CDB request (bit i = issuer i)
req_data  input  NUM_REQ*DATA_WIDTH  issuer i result in slice [i*DATA_WIDTH +: DATA_WIDTH]
req_id  input  NUM_REQ*ROB_ENTRY_LOG2  issuer i ROB tag in slice [i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2]
req_grant  output  NUM_REQ  one-hot/zero grant; issuer i handshake = req_request[i] & req_grant[i]
flush  input  1  pipeline flush (branch mispredict/exception)
cdb_valid  output  1  broadcast valid
cdb_data  output  DATA_WIDTH  broadcast result
cdb_id  output  ROB_ENTRY_LOG2  broadcast ROB tag

Behaviour:
- Reset values: cdb_valid=0, cdb_data=0, cdb_id=0, rr_ptr=0. req_grant is forced to 0 while RSTN=0.
- Grant is combinational in the same cycle as the request, so issuers see the handshake immediately.
- Arbitration: scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first index with req_request set wins. req_grant is one-hot on the winner, or all-zero if there is no request.
- req_grant[i]=1 only if req_request[i]=1; a grant to a non-requesting issuer is never allowed.
- flush=1: req_grant is forced to 0 and rr_ptr holds.
- rr_ptr, log2 of NUM_REQ bits:
  - on a grant to issuer w, rr_ptr <= (w+1) mod NUM_REQ, so w=NUM_REQ-1 wraps to 0;
  - with no grant, rr_ptr holds.
- Broadcast stage, registered, latency 1:
  - cycle T grant to w -> cycle T+1: cdb_valid=1, cdb_data=req_data[w] sampled at T, cdb_id=req_id[w] sampled at T;
  - no grant at T (including flush) -> cdb_valid=0 at T+1, with cdb_data/cdb_id holding their last values.
- Flush does not mask a cdb_valid already registered in the flush cycle; the consumers own squash of that broadcast.
- Full throughput: back-to-back grants every cycle; continuous requesters are served in rotation. With all NUM_REQ requesting, each is granted exactly once per NUM_REQ cycles. Starvation bound is NUM_REQ-1 cycles of waiting.
- Issuers must hold request/data/id stable until granted. The arbiter does not latch losing requests.
- Requests with unknown (X) values are not allowed out of reset.
- Reset asserted mid-operation: outputs and rr_ptr return to reset values immediately (async). A broadcast in flight is lost.

Decomposition:
- Shared package:
  - CDB field widths (DATA_WIDTH, ROB_ENTRY_LOG2 derivation);
  - issuer index constants: ISSUER_ALU=0, ISSUER_LSU=1, ISSUER_BRU=2;
  - NUM_REQ default.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], ptr, en;
  - output one-hot gnt[N] plus encoded winner index and any_gnt;
  - purely combinational.
- cdb_arbiter keeps rr_ptr, the broadcast register, flush masking and the data/id mux.

Test Plan:
1. Single request: req_request=3'b001, data 0x0000_1234, id 2 -> req_grant=3'b001 same cycle; next cycle cdb_valid=1, cdb_data=0x1234, cdb_id=2; rr_ptr=1.
2. Simultaneous requests from reset: req_request=3'b101 held -> grants 001, 100, 001, 100 on successive cycles (handshaking issuer drops its request after its second grant). cdb_id follows grant order with 1-cycle lag.
3. Full contention and wrap: all three requesting continuously for 6 cycles -> grants 001, 010, 100, 001, 010, 100; rr_ptr wraps 2->0; cdb_valid=1 for 6 consecutive cycles starting one cycle after the first grant.
4. Flush: requests 3'b011 with flush=1 for one cycle -> req_grant=000 that cycle; cdb_valid=0 next cycle; rr_ptr unchanged. Arbitration resumes from the same pointer the cycle after.
5. Idle: no requests for 3 cycles after a broadcast of 0xDEAD_BEEF -> cdb_valid=0; cdb_data stays 0xDEAD_BEEF; rr_ptr unchanged.
6. Reset mid-operation: assert RSTN=0 asynchronously while cdb_valid=1 and rr_ptr=2 -> cdb_valid, cdb_data, cdb_id go to 0 and req_grant to 000 immediately. After release, request 3'b100 is granted and rr_ptr becomes 0.
